// File: rtl/quote_scheduler_pkg.sv
// ============================================================================
// quote_scheduler_pkg - shared FSM state type and defaults (rev 1.0)
// ============================================================================
`default_nettype none

package quote_scheduler_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/quote_scheduler_rr_arbiter.sv
// ============================================================================
// rr_arbiter - round-robin grant search starting at a rotating pointer (rev 1.0)
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // NUM_REQ is a power of two, so the index sum wraps naturally.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_i + IDX_W'(k);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/quote_scheduler.sv
// ============================================================================
// quote_scheduler - arbitrates strategy requests onto one quote-price unit (rev 1.0)
// ============================================================================
`default_nettype none

module quote_scheduler
  import quote_scheduler_pkg::*;
#(
  parameter int FP_WORD_SIZE = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*FP_WORD_SIZE-1:0] i_req_ref_price,
  input  logic [NUM_REQ*FP_WORD_SIZE-1:0] i_req_spread,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [FP_WORD_SIZE-1:0]         o_qp_ref_price,
  output logic [FP_WORD_SIZE-1:0]         o_qp_spread,
  output logic                            o_qp_data_valid,
  input  logic [DATA_WIDTH-1:0]           i_qp_buy_price,
  input  logic [DATA_WIDTH-1:0]           i_qp_ask_price,
  input  logic                            i_qp_data_valid,
  output logic [DATA_WIDTH-1:0]           o_buy_price,
  output logic [DATA_WIDTH-1:0]           o_ask_price,
  output logic                            o_quote_valid,
  output logic [$clog2(NUM_REQ)-1:0]      o_quote_id,
  output logic                            o_timeout_err
);

  localparam int                IDX_W    = $clog2(NUM_REQ);
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [FP_WORD_SIZE-1:0]  ref_q, ref_d;
  logic [FP_WORD_SIZE-1:0]  spread_q, spread_d;
  logic [DATA_WIDTH-1:0]    buy_q, buy_d;
  logic [DATA_WIDTH-1:0]    ask_q, ask_d;

  logic [NUM_REQ-1:0]       arb_grant;
  logic [IDX_W-1:0]         arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i       (i_req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx)
  );

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    wait_cnt_d      = wait_cnt_q;
    ref_d           = ref_q;
    spread_d        = spread_q;
    buy_d           = buy_q;
    ask_d           = ask_q;
    o_req_ready     = '0;
    o_qp_data_valid = 1'b0;
    o_quote_valid   = 1'b0;
    o_timeout_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_req_ready = arb_grant;
        if (|i_req_valid) begin
          grant_d  = arb_idx;
          ref_d    = i_req_ref_price[int'(arb_idx)*FP_WORD_SIZE +: FP_WORD_SIZE];
          spread_d = i_req_spread[int'(arb_idx)*FP_WORD_SIZE +: FP_WORD_SIZE];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_qp_data_valid = 1'b1;
        wait_cnt_d      = '0;
        state_d         = ST_WAIT;
      end
      ST_WAIT: begin
        // A result on the final wait cycle takes priority over the abort.
        if (i_qp_data_valid) begin
          buy_d   = i_qp_buy_price;
          ask_d   = i_qp_ask_price;
          state_d = ST_DONE;
        end else if (wait_cnt_q == CNT_LAST) begin
          o_timeout_err = 1'b1;
          rr_ptr_d      = grant_q + IDX_ONE;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        o_quote_valid = 1'b1;
        rr_ptr_d      = grant_q + IDX_ONE;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      wait_cnt_q <= '0;
      ref_q      <= '0;
      spread_q   <= '0;
      buy_q      <= '0;
      ask_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      wait_cnt_q <= wait_cnt_d;
      ref_q      <= ref_d;
      spread_q   <= spread_d;
      buy_q      <= buy_d;
      ask_q      <= ask_d;
    end
  end

  assign o_qp_ref_price = ref_q;
  assign o_qp_spread    = spread_q;
  assign o_buy_price    = buy_q;
  assign o_ask_price    = ask_q;
  assign o_quote_id     = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_quote_scheduler.sv
// ============================================================================
// tb_quote_scheduler - self-checking bench for quote_scheduler (rev 1.0)
// ============================================================================
`default_nettype none

module tb_quote_scheduler;

  localparam int FP  = 64;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int TO  = 16;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*FP-1:0]  req_ref;
  logic [NR*FP-1:0]  req_spr;
  logic [NR-1:0]     req_ready;
  logic [FP-1:0]     qp_ref;
  logic [FP-1:0]     qp_spr;
  logic              qp_out_valid;
  logic [DW-1:0]     qp_buy;
  logic [DW-1:0]     qp_ask;
  logic              qp_in_valid;
  logic [DW-1:0]     buy_price;
  logic [DW-1:0]     ask_price;
  logic              quote_valid;
  logic [1:0]        quote_id;
  logic              timeout_err;

  logic [FP-1:0]     ref_arr [NR];
  logic [FP-1:0]     spr_arr [NR];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: rotating pointer and last captured prices.
  int            m_ptr;
  logic [DW-1:0] m_buy;
  logic [DW-1:0] m_ask;

  assign req_ref = {ref_arr[3], ref_arr[2], ref_arr[1], ref_arr[0]};
  assign req_spr = {spr_arr[3], spr_arr[2], spr_arr[1], spr_arr[0]};

  quote_scheduler #(
    .FP_WORD_SIZE (FP),
    .DATA_WIDTH   (DW),
    .NUM_REQ      (NR),
    .TIMEOUT      (TO)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .i_req_ref_price (req_ref),
    .i_req_spread    (req_spr),
    .o_req_ready     (req_ready),
    .o_qp_ref_price  (qp_ref),
    .o_qp_spread     (qp_spr),
    .o_qp_data_valid (qp_out_valid),
    .i_qp_buy_price  (qp_buy),
    .i_qp_ask_price  (qp_ask),
    .i_qp_data_valid (qp_in_valid),
    .o_buy_price     (buy_price),
    .o_ask_price     (ask_price),
    .o_quote_valid   (quote_valid),
    .o_quote_id      (quote_id),
    .o_timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_operands();
    for (int k = 0; k < NR; k++) begin
      ref_arr[k] = {$urandom, $urandom};
      spr_arr[k] = {$urandom, $urandom};
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"},      64'(req_ready),    64'd0);
    chk({tag, ".qp_ref"},     qp_ref,            64'd0);
    chk({tag, ".qp_spread"},  qp_spr,            64'd0);
    chk({tag, ".qp_valid"},   64'(qp_out_valid), 64'd0);
    chk({tag, ".buy"},        64'(buy_price),    64'd0);
    chk({tag, ".ask"},        64'(ask_price),    64'd0);
    chk({tag, ".quote_valid"},64'(quote_valid),  64'd0);
    chk({tag, ".quote_id"},   64'(quote_id),     64'd0);
    chk({tag, ".timeout"},    64'(timeout_err),  64'd0);
  endtask

  // Requester chosen: first valid one scanning upward from the pointer.
  function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  // One full transaction starting in an idle cycle with req_valid already driven.
  // lat > TO means the result is never returned.
  task automatic do_txn(input int exp_id, input int lat);
    logic [FP-1:0] er, es;
    logic [DW-1:0] bp, ap;
    logic [NR-1:0] oh;
    bit            tmo;
    int            e_end;
    tmo   = (lat > TO);
    e_end = tmo ? TO + 1 : lat + 2;
    bp    = $urandom;
    ap    = $urandom;
    er    = ref_arr[exp_id];
    es    = spr_arr[exp_id];
    oh    = 4'b0001 << exp_id;
    @(negedge clk);
    chk("accept.ready", 64'(req_ready), 64'(oh));
    tick();
    new_operands();
    @(negedge clk);
    chk("issue.qp_valid", 64'(qp_out_valid), 64'd1);
    chk("issue.qp_ref",   qp_ref, er);
    chk("issue.qp_spread",qp_spr, es);
    chk("issue.ready",    64'(req_ready), 64'd0);
    for (int c = 2; c <= e_end; c++) begin
      tick();
      qp_in_valid = (!tmo && c == lat + 1);
      qp_buy      = (c == lat + 1) ? bp : DW'($urandom);
      qp_ask      = (c == lat + 1) ? ap : DW'($urandom);
      @(negedge clk);
      chk("wait.quote_valid", 64'(quote_valid), 64'(!tmo && c == e_end));
      chk("wait.timeout",     64'(timeout_err), 64'(tmo && c == e_end));
    end
    if (!tmo) begin
      m_buy = bp;
      m_ask = ap;
    end
    chk("end.quote_id", 64'(quote_id),  64'(exp_id));
    chk("end.buy",      64'(buy_price), 64'(m_buy));
    chk("end.ask",      64'(ask_price), 64'(m_ask));
    chk("end.qp_hold",  qp_ref, er);
    tick();
    qp_in_valid = 1'b0;
    m_ptr = (exp_id + 1) % NR;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    int            lat;
    int            id;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{4'b0100, 3,  2};
    tbl[1]  = '{4'b1111, 1,  3};
    tbl[2]  = '{4'b1111, 2,  0};
    tbl[3]  = '{4'b1111, 5,  1};
    tbl[4]  = '{4'b1111, 16, 2};
    tbl[5]  = '{4'b1111, 99, 3};
    tbl[6]  = '{4'b0011, 4,  0};
    tbl[7]  = '{4'b0001, 2,  0};
    tbl[8]  = '{4'b1001, 1,  3};
    tbl[9]  = '{4'b0110, 99, 1};
    tbl[10] = '{4'b0010, 3,  1};

    rst_n       = 1'b0;
    req_valid   = '0;
    qp_in_valid = 1'b0;
    qp_buy      = '0;
    qp_ask      = '0;
    m_ptr       = 0;
    m_buy       = '0;
    m_ask       = '0;
    new_operands();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      req_valid = tbl[i].valid;
      do_txn(tbl[i].id, tbl[i].lat);
    end

    // Stray result strobe while idle must not disturb anything.
    req_valid   = '0;
    qp_in_valid = 1'b1;
    qp_buy      = ~m_buy;
    qp_ask      = ~m_ask;
    @(negedge clk);
    chk("stray.ready",       64'(req_ready),   64'd0);
    chk("stray.quote_valid", 64'(quote_valid), 64'd0);
    tick();
    qp_in_valid = 1'b0;
    @(negedge clk);
    chk("stray.buy",         64'(buy_price),    64'(m_buy));
    chk("stray.ask",         64'(ask_price),    64'(m_ask));
    chk("stray.quote_valid2",64'(quote_valid),  64'd0);
    chk("stray.qp_valid",    64'(qp_out_valid), 64'd0);
    tick();

    // Reset in the middle of WAIT, then a late result.
    req_valid = 4'b0100;
    repeat (4) tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    rst_n       = 1'b1;
    m_ptr       = 0;
    m_buy       = '0;
    m_ask       = '0;
    tick();
    qp_in_valid = 1'b1;
    qp_buy      = 32'hDEAD_BEEF;
    qp_ask      = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late.quote_valid", 64'(quote_valid), 64'd0);
    tick();
    qp_in_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("late");
    tick();

    // Continuous demand from everyone: strict rotation from requester 0.
    req_valid = 4'b1111;
    do_txn(0, 2);
    do_txn(1, 1);
    do_txn(2, 3);
    do_txn(3, 1);
    do_txn(0, 2);

    for (int i = 0; i < 40; i++) begin
      logic [NR-1:0] v;
      int            lat;
      v         = NR'($urandom_range(1, 15));
      lat       = $urandom_range(1, TO + 3);
      req_valid = v;
      do_txn(model_pick(v, m_ptr), lat);
    end

    req_valid = '0;
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quote_scheduler.md
QUOTE_SCHEDULER -- requirements
Module: quote_scheduler

Interface
REQ-001 SHALL have parameter FP_WORD_SIZE, default 64, fixed-point operand width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, quote price width.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of strategy requesters (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum WAIT cycles before abort.
REQ-005 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_req_valid, input, NUM_REQ, per-requester request valid.
REQ-008 SHALL have port i_req_ref_price, input, NUM_REQ*FP_WORD_SIZE, packed reference prices, requester k at slice k.
REQ-009 SHALL have port i_req_spread, input, NUM_REQ*FP_WORD_SIZE, packed spreads, same packing.
REQ-010 SHALL have port o_req_ready, output, NUM_REQ, one-hot accept to the granted requester.
REQ-011 SHALL have port o_qp_ref_price, output, FP_WORD_SIZE, operand to the quote-price unit.
REQ-012 SHALL have port o_qp_spread, output, FP_WORD_SIZE, operand to the quote-price unit.
REQ-013 SHALL have port o_qp_data_valid, output, 1, operand strobe to the quote-price unit.
REQ-014 SHALL have ports i_qp_buy_price and i_qp_ask_price, input, DATA_WIDTH each, results from the quote-price unit.
REQ-015 SHALL have port i_qp_data_valid, input, 1, result strobe from the quote-price unit.
REQ-016 SHALL have ports o_buy_price and o_ask_price, output, DATA_WIDTH each, registered quote.
REQ-017 SHALL have port o_quote_valid, output, 1, one-cycle quote strobe.
REQ-018 SHALL have port o_quote_id, output, $clog2(NUM_REQ), requester index of the quote.
REQ-019 SHALL have port o_timeout_err, output, 1, one-cycle abort strobe; o_quote_id is valid with it.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE, with one transaction outstanding.
REQ-021 In IDLE with any i_req_valid set, SHALL grant round-robin starting at rr_ptr, assert o_req_ready[grant] combinationally, latch that requester's operands and id, and go to ISSUE; with no request, SHALL remain in IDLE.
REQ-022 o_req_ready SHALL be all-zero outside IDLE; handshake = valid & ready in the same cycle.
REQ-023 ISSUE SHALL drive the latched operands with o_qp_data_valid=1 for exactly one cycle, clear wait_cnt, then go to WAIT.
REQ-024 WAIT with i_qp_data_valid=1 SHALL register buy/ask into o_buy_price/o_ask_price and go to DONE.
REQ-025 WAIT with wait_cnt==TIMEOUT-1 and no result SHALL pulse o_timeout_err, set rr_ptr=grant+1 mod NUM_REQ and go to IDLE; if a result arrives on that same cycle, the result SHALL win and no error is raised.
REQ-026 DONE SHALL pulse o_quote_valid with o_quote_id=grant for one cycle, set rr_ptr=grant+1 mod NUM_REQ and go to IDLE.
REQ-027 i_qp_data_valid outside WAIT SHALL be ignored, with no state or output change.
REQ-028 Latency: accept at cycle 0, o_qp_data_valid at 1, result at 1+L, o_quote_valid at 2+L, earliest next accept at 3+L.
REQ-029 o_qp_ref_price and o_qp_spread SHALL hold their latched values between issues; o_buy_price and o_ask_price SHALL hold until the next capture.

Reset
REQ-030 Asserting i_rst_n low at any time, including mid-WAIT, SHALL asynchronously force IDLE, rr_ptr=0, wait_cnt=0, and all outputs to 0; a late result after reset SHALL be ignored per REQ-027.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and a default TIMEOUT constant.
REQ-032 The round-robin arbiter SHALL be sub-module rr_arbiter (inputs: request vector and rr_ptr; outputs: one-hot grant and grant index).

Verification
REQ-033 Single request: requester 2 valid, quote-price latency 3 -> ready[2] at cycle 0, qp strobe at 1, o_quote_valid at 5 with id=2 and prices matching the model.
REQ-034 All four requesters continuously valid -> quote ids in order 0,1,2,3,0; no requester starves.
REQ-035 Result never returned, TIMEOUT=16 -> o_timeout_err at cycle 17 after accept, no quote_valid, next grant goes to grant+1.
REQ-036 Result arrives exactly on the timeout cycle -> o_quote_valid asserts and o_timeout_err stays low.
REQ-037 Reset asserted mid-WAIT, then the late result arrives -> all outputs stay 0, FSM is in IDLE, no quote is emitted.
REQ-038 Stray i_qp_data_valid while in IDLE -> no output change.
